// File: rtl/slurm_uart_pkg.sv
// Shared definitions for the slurm16 UART transmitter: FSM states,
// frame geometry and the baud divisor calculation.
package slurm_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Rounded integer divisor: clocks per bit period.
    function automatic int calc_div(input int clock_freq, input int baud_rate);
        return (clock_freq + baud_rate / 2) / baud_rate;
    endfunction

endpackage

// File: rtl/slurm_uart_fifo.sv
// Synchronous byte FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguishable; the head is a direct array read.
module slurm_uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RSTb,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // Pointer update; a push into a full FIFO is dropped even if a pop
    // happens on the same edge.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge CLK) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/slurm_uart_tx.sv
// Buffered 8N1 UART transmitter. Bus writes land in a FIFO; the FSM pops
// one byte per frame and drives a registered, glitch-free serial line.
module slurm_uart_tx
    import slurm_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 10000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLK,
    input  logic                          RSTb,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          uart_tx
);

    localparam int                DIV      = calc_div(CLOCK_FREQ, BAUD_RATE);
    localparam int                CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_e       state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_dout;
    logic              pop;
    logic              baud_done;

    slurm_uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RSTb  (RSTb),
        .push  (wr_valid),
        .din   (wr_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign wr_ready  = !fifo_full;
    assign baud_done = (baud_cnt == CNT_LAST);

    // Pop when idle, or at the last stop-bit cycle so frames run back to back.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty && (state == IDLE || (state == STOP && baud_done)))
            pop = 1'b1;
    end

    // Frame FSM. The line register follows the current state one cycle
    // later, which gives the two-cycle write-to-start-bit latency and
    // keeps every level exactly DIV cycles long.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            busy <= (state != IDLE) || !fifo_empty;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    uart_tx <= 1'b0;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    uart_tx <= shift[0];
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_idx == BIT_LAST)
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    uart_tx <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_dout;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
